// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and address decode for the
// instruction-memory responder (state enum, counter width, fill word).
package imem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int CNT_W = 4;

    // ebreak, returned for any fetch that misses the array
    localparam logic [31:0] IMEM_FILL_WORD = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] idx;
        logic        in_range;
    } dec_t;

    // Offset from the base wraps in 32 bits, so addresses below the
    // base land far above the array and decode as out of range.
    function automatic dec_t decode(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        dec_t        d;
        logic [31:0] off;
        logic [31:0] lim;
        off        = addr - base;
        lim        = 32'(depth) << 2;
        d.idx      = off >> 2;
        d.in_range = (off < lim) && (addr[1:0] == 2'b00);
        return d;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response bus between the fetch unit
// (master) and the instruction memory (slave), including wait-state stall.
interface imem_responder_if;

    logic        io_reqValid;
    logic [31:0] io_addr;
    logic        stall;
    logic        io_respValid;
    logic [31:0] io_rdata;
    logic        resp_err;

    modport master (
        output io_reqValid,
        output io_addr,
        output stall,
        input  io_respValid,
        input  io_rdata,
        input  resp_err
    );

    modport slave (
        input  io_reqValid,
        input  io_addr,
        input  stall,
        output io_respValid,
        output io_rdata,
        output resp_err
    );

endinterface

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 word store, async read port, sync write port.
// Ports: clock, we/waddr/wdata (write), raddr/rdata (read). Not reset.
module imem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int          AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is combinational, so a same-cycle write is seen only
    // after the clock edge (read-old-data).
    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// imem_responder: answers one-cycle fetch requests after LATENCY cycles
// (stall extends the wait), with a side loader write port.
// Ports: clock, reset (sync, active-high), io (fetch bus slave),
//   ld_we/ld_addr/ld_wdata (loader), proto_err (sticky request-while-busy).
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] FILL_WORD = IMEM_FILL_WORD
) (
    input  logic              clock,
    input  logic              reset,
    imem_responder_if.slave   io,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              proto_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_INIT =
        (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [AW-1:0]    lat_idx, lat_idx_n;
    logic             lat_ok, lat_ok_n;
    logic             proto_n;

    dec_t             req_dec;
    dec_t             ld_dec;
    logic [AW-1:0]    raddr;
    logic [31:0]      mem_rd;

    logic             resp;
    logic [31:0]      rdata;
    logic             err;

    assign req_dec = decode(io.io_addr, BASE_ADDR, DEPTH);
    assign ld_dec  = decode(ld_addr, BASE_ADDR, DEPTH);

    logic unused_idx;
    assign unused_idx = ^{req_dec.idx[31:AW], ld_dec.idx[31:AW]};

    // While waiting, read from the latched index so loader writes that
    // land between request and response are returned.
    assign raddr = (state == WAIT) ? lat_idx : req_dec.idx[AW-1:0];

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock (clock),
        .we    (ld_we & ld_dec.in_range),
        .waddr (ld_dec.idx[AW-1:0]),
        .wdata (ld_wdata),
        .raddr (raddr),
        .rdata (mem_rd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_ok    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lat_idx   <= lat_idx_n;
            lat_ok    <= lat_ok_n;
            proto_err <= proto_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        lat_idx_n = lat_idx;
        lat_ok_n  = lat_ok;
        proto_n   = proto_err;
        resp      = 1'b0;
        rdata     = '0;
        err       = 1'b0;
        // A cycle under reset never responds, even if a wait was due.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (io.io_reqValid) begin
                        if (LATENCY == 0) begin
                            resp  = 1'b1;
                            err   = !req_dec.in_range;
                            rdata = req_dec.in_range ? mem_rd
                                                     : FILL_WORD;
                        end else begin
                            lat_idx_n = req_dec.idx[AW-1:0];
                            lat_ok_n  = req_dec.in_range;
                            cnt_n     = CNT_INIT;
                            state_n   = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (io.io_reqValid) begin
                        proto_n = 1'b1;
                    end
                    if (!io.stall) begin
                        if (cnt != '0) begin
                            cnt_n = cnt - CNT_W'(1);
                        end else begin
                            resp    = 1'b1;
                            err     = !lat_ok;
                            rdata   = lat_ok ? mem_rd : FILL_WORD;
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign io.io_respValid = resp;
    assign io.io_rdata     = rdata;
    assign io.resp_err     = err;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: four responders (LATENCY 0,3,2,4) sharing one loader,
// directed cases then random traffic against a cycle-level reference model.
module tb_imem_responder;

    localparam int          NI    = 4;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] FILL  = 32'h0010_0073;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 0;
            1:       return 3;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    logic        clk;
    logic        rst;
    logic        req_v [NI];
    logic [31:0] req_a [NI];
    logic        stl   [NI];
    wire         rv    [NI];
    wire  [31:0] rd    [NI];
    wire         re    [NI];
    wire         pe    [NI];
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;

    for (genvar g = 0; g < NI; g++) begin : gi
        imem_responder_if bus();
        assign bus.io_reqValid = req_v[g];
        assign bus.io_addr     = req_a[g];
        assign bus.stall       = stl[g];
        assign rv[g]           = bus.io_respValid;
        assign rd[g]           = bus.io_rdata;
        assign re[g]           = bus.resp_err;

        imem_responder #(
            .LATENCY (lat_of(g))
        ) dut (
            .clock     (clk),
            .reset     (rst),
            .io        (bus),
            .ld_we     (ld_we),
            .ld_addr   (ld_addr),
            .ld_wdata  (ld_wdata),
            .proto_err (pe[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit          pend   [NI];
    int          need   [NI];
    logic [31:0] paddr  [NI];
    logic        mproto [NI];
    bit          proto_known = 0;
    logic [31:0] mm [DEPTH];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [31:0] a, output int idx);
        logic [31:0] off;
        off = a - BASE;
        idx = int'(off >> 2);
        return (off < 32'(DEPTH * 4)) && (a[1:0] == 2'b00);
    endfunction

    function automatic void fetch(input logic [31:0] a,
                                  output logic [31:0] d,
                                  output logic e);
        int idx;
        if (hit(a, idx)) begin
            d = mm[idx];
            e = 1'b0;
        end else begin
            d = FILL;
            e = 1'b1;
        end
    endfunction

    // Called once per cycle with inputs stable: predicts and checks the
    // outputs, then advances the model across the coming clock edge.
    task automatic model_and_check();
        int widx;
        for (int g = 0; g < NI; g++) begin
            logic        ev, ee, np;
            logic [31:0] ed;
            ev = 1'b0;
            ee = 1'b0;
            ed = '0;
            np = mproto[g];
            if (rst) begin
                pend[g] = 0;
                np      = 1'b0;
            end else if (pend[g]) begin
                if (req_v[g]) np = 1'b1;
                if (!stl[g]) begin
                    need[g]--;
                    if (need[g] == 0) begin
                        ev = 1'b1;
                        fetch(paddr[g], ed, ee);
                        pend[g] = 0;
                    end
                end
            end else if (req_v[g]) begin
                if (lat_of(g) == 0) begin
                    ev = 1'b1;
                    fetch(req_a[g], ed, ee);
                end else begin
                    pend[g]  = 1;
                    need[g]  = lat_of(g);
                    paddr[g] = req_a[g];
                end
            end
            check($sformatf("resp_valid[%0d]", g), 32'(rv[g]), 32'(ev));
            check($sformatf("rdata[%0d]", g), rd[g], ed);
            check($sformatf("resp_err[%0d]", g), 32'(re[g]), 32'(ee));
            if (proto_known)
                check($sformatf("proto_err[%0d]", g),
                      32'(pe[g]), 32'(mproto[g]));
            mproto[g] = np;
        end
        if (ld_we && hit(ld_addr, widx)) mm[widx] = ld_wdata;
        proto_known = 1;
    endtask

    task automatic step();
        @(negedge clk);
        model_and_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int g = 0; g < NI; g++) begin
            req_v[g] = 1'b0;
            stl[g]   = 1'b0;
            req_a[g] = BASE;
        end
        ld_we    = 1'b0;
        ld_addr  = BASE;
        ld_wdata = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return $urandom();
        if (r < 3)
            return BASE + 32'($urandom_range(0, 1100)) * 4
                        + 32'($urandom_range(0, 3));
        return BASE + 32'($urandom_range(0, 15)) * 4;
    endfunction

    initial begin
        int pulses;
        idle_all();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // preload every word so all reads are known
        for (int i = 0; i < DEPTH; i++) begin
            ld_we   = 1'b1;
            ld_addr = BASE + 32'(i) * 4;
            case (i)
                0:       ld_wdata = 32'h0000_0513;
                1:       ld_wdata = 32'hDEAD_BEEF;
                5:       ld_wdata = 32'h5555_5555;
                default: ld_wdata = $urandom();
            endcase
            step();
        end
        idle_all();
        step();

        // LATENCY 0: same-cycle response, back-to-back
        req_v[0] = 1'b1;
        req_a[0] = BASE;
        #2;
        check("l0_valid", 32'(rv[0]), 32'd1);
        check("l0_data", rd[0], 32'h0000_0513);
        step();
        for (int k = 0; k < 3; k++) begin
            req_a[0] = BASE + 32'(k) * 4;
            #2;
            check("l0_b2b_valid", 32'(rv[0]), 32'd1);
            step();
        end
        req_v[0] = 1'b0;

        // out of range and misaligned
        req_v[0] = 1'b1;
        req_a[0] = 32'h8000_1000;
        #2;
        check("oor_data", rd[0], FILL);
        check("oor_err", 32'(re[0]), 32'd1);
        step();
        req_a[0] = 32'h8000_0002;
        #2;
        check("mis_data", rd[0], FILL);
        check("mis_err", 32'(re[0]), 32'd1);
        step();
        req_v[0] = 1'b0;
        step();

        // LATENCY 3: response exactly three cycles later
        req_v[1] = 1'b1;
        req_a[1] = BASE + 4;
        #2;
        check("l3_t0", 32'(rv[1]), 32'd0);
        step();
        req_v[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #2;
            check("l3_valid", 32'(rv[1]), 32'(k == 3));
            check("l3_data", rd[1], (k == 3) ? 32'hDEAD_BEEF : 32'h0);
            step();
        end

        // LATENCY 2 with three stalled cycles
        req_v[2] = 1'b1;
        req_a[2] = BASE + 8;
        step();
        req_v[2] = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            stl[2] = (k <= 3);
            #2;
            check("l2_valid", 32'(rv[2]), 32'(k == 5));
            if (rv[2]) pulses++;
            step();
        end
        stl[2] = 1'b0;
        check("l2_pulses", 32'(pulses), 32'd1);

        // loader write in the response cycle returns old data
        req_v[1] = 1'b1;
        req_a[1] = BASE + 20;
        step();
        req_v[1] = 1'b0;
        step();
        step();
        ld_we    = 1'b1;
        ld_addr  = BASE + 20;
        ld_wdata = 32'h1111_1111;
        #2;
        check("ld_old_valid", 32'(rv[1]), 32'd1);
        check("ld_old_data", rd[1], 32'h5555_5555);
        step();
        ld_we    = 1'b0;
        req_v[1] = 1'b1;
        step();
        req_v[1] = 1'b0;
        step();
        step();
        #2;
        check("ld_new_data", rd[1], 32'h1111_1111);
        step();

        // LATENCY 4: request while busy
        for (int k = 0; k <= 5; k++) begin
            req_v[3] = (k == 0 || k == 2);
            req_a[3] = BASE;
            #2;
            check("l4_valid", 32'(rv[3]), 32'(k == 4));
            check("l4_proto", 32'(pe[3]), 32'(k >= 3));
            step();
        end

        // reset while waiting discards the request
        for (int k = 0; k <= 6; k++) begin
            req_v[3] = (k == 0);
            rst      = (k == 2);
            #2;
            check("rst_valid", 32'(rv[3]), 32'd0);
            if (k >= 3) check("rst_proto", 32'(pe[3]), 32'd0);
            step();
        end
        idle_all();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int g = 0; g < NI; g++) begin
                stl[g] = ($urandom_range(0, 3) == 0);
                if (!pend[g])
                    req_v[g] = ($urandom_range(0, 2) == 0);
                else
                    req_v[g] = ($urandom_range(0, 99) == 0);
                req_a[g] = rand_addr();
            end
            ld_we    = !rst && ($urandom_range(0, 2) == 0);
            ld_addr  = rand_addr();
            ld_wdata = $urandom();
            step();
        end
        rst = 1'b0;
        idle_all();
        for (int k = 0; k < 6; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
